// File: rtl/cnt_sec_min_hr_pkg.sv
// Time-of-day field moduli, widths and the packed time bundle.
// Shared by the counter top, its interface and the field counters.
package clk_time_pkg;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [MIN_W-1:0] min;
    logic [HR_W-1:0]  hr;
  } time_t;

endpackage

// File: rtl/cnt_sec_min_hr_if.sv
// Time-of-day output bundle: sec, min, hr.
// master drives the fields, slave (display/alarm) reads them.
interface cnt_sec_min_hr_if;
  import clk_time_pkg::*;

  logic [SEC_W-1:0] sec;
  logic [MIN_W-1:0] min;
  logic [HR_W-1:0]  hr;

  modport master (output sec, min, hr);
  modport slave  (input  sec, min, hr);

endinterface

// File: rtl/cnt_sec_min_hr_cnt_mod_n.sv
// Modulo-MOD counter with enable; wrap flags the en edge at MOD-1.
// Ports: clk, rst_n (sync, low), en in; q[W-1:0], wrap out.
module cnt_mod_n #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max;

  always_comb begin
    at_max = (cnt_q == W'(MOD - 1));
    wrap   = en & at_max;
    cnt_d  = cnt_q;
    if (en) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/cnt_sec_min_hr.sv
// Time-of-day counter hh:mm:ss, one second per TICK_DIV clocks.
// Ports: clk, rst_n (sync, low); tm.master carries sec/min/hr.
module cnt_sec_min_hr
  import clk_time_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cnt_sec_min_hr_if.master    tm
);

  logic  tick;
  logic  sec_wrap;
  logic  min_wrap;
  logic  hr_wrap;
  time_t t;

  if (TICK_DIV == 1) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
      pre_d = pre_q + PW'(1);
      if (pre_q == PW'(TICK_DIV - 1)) pre_d = '0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) pre_q <= '0;
      else        pre_q <= pre_d;
    end

    assign tick = (pre_q == PW'(TICK_DIV - 1));
  end

  // Carries ripple combinationally so all fields move on one edge.
  cnt_mod_n #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick),
    .q     (t.sec),
    .wrap  (sec_wrap)
  );

  cnt_mod_n #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_wrap),
    .q     (t.min),
    .wrap  (min_wrap)
  );

  cnt_mod_n #(.MOD(HR_MOD), .W(HR_W)) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_wrap),
    .q     (t.hr),
    .wrap  (hr_wrap)
  );

  assign tm.sec = t.sec;
  assign tm.min = t.min;
  assign tm.hr  = t.hr;

  logic unused;
  assign unused = hr_wrap;

endmodule

// File: tb/tb_cnt_sec_min_hr.sv
// Bench for cnt_sec_min_hr: TICK_DIV=1 and TICK_DIV=4 instances.
// Expected time comes from a seconds-of-day model.
module tb_cnt_sec_min_hr;

  logic clk;
  logic rst1;
  logic rst4;

  cnt_sec_min_hr_if t1 ();
  cnt_sec_min_hr_if t4 ();

  cnt_sec_min_hr #(.TICK_DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst1),
    .tm    (t1.master)
  );

  cnt_sec_min_hr #(.TICK_DIV(4)) dut4 (
    .clk   (clk),
    .rst_n (rst4),
    .tm    (t4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Model: seconds since midnight, plus edges since release for dut4.
  int m1;
  int m4;
  int e4;

  function automatic logic [16:0] hms(input int s);
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] c;
    h = 5'(s / 3600);
    m = 6'((s / 60) % 60);
    c = 6'(s % 60);
    return {h, m, c};
  endfunction

  function automatic logic [16:0] got1();
    return {t1.hr, t1.min, t1.sec};
  endfunction

  function automatic logic [16:0] got4();
    return {t4.hr, t4.min, t4.sec};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
    if (!rst1) m1 = 0;
    else       m1 = (m1 + 1) % 86400;
    if (!rst4) begin
      e4 = 0;
      m4 = 0;
    end else begin
      e4++;
      if (e4 % 4 == 0) m4 = (m4 + 1) % 86400;
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv();
      n_checks++;
      if (got1() !== 17'd0)
        $display("FAIL reset_hold[%0d] got %h want 0", i, got1());
      else n_pass++;
    end
    rst1 = 1'b1;
    adv();
    n_checks++;
    if (got1() !== hms(1))
      $display("FAIL reset_release got %h want %h", got1(), hms(1));
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    while (m1 != 2950) adv();
    n_checks++;
    if (got1() !== {5'd0, 6'd49, 6'd10})
      $display("FAIL mid_pre got %h want 00:49:10", got1());
    else n_pass++;
    rst1 = 1'b0;
    adv();
    n_checks++;
    if (got1() !== 17'd0)
      $display("FAIL mid_reset got %h want 0", got1());
    else n_pass++;
    rst1 = 1'b1;
    adv();
    n_checks++;
    if (got1() !== {5'd0, 6'd0, 6'd1})
      $display("FAIL mid_resume got %h want 00:00:01", got1());
    else n_pass++;
  endtask

  // Runs a full day from release; every edge is checked against the model.
  task automatic test_day();
    logic [16:0] g;
    for (int n = 2; n <= 86401; n++) begin
      adv();
      g = got1();
      n_checks++;
      if (g !== hms(m1) || t1.sec > 59 || t1.min > 59 || t1.hr > 23)
        $display("FAIL day_edge%0d got %h want %h", n, g, hms(m1));
      else n_pass++;
      if (n == 59 || n == 60 || n == 3599 || n == 3600 ||
          n == 86399 || n == 86400 || n == 86401) begin
        logic [16:0] want;
        unique case (n)
          59:      want = {5'd0,  6'd0,  6'd59};
          60:      want = {5'd0,  6'd1,  6'd0};
          3599:    want = {5'd0,  6'd59, 6'd59};
          3600:    want = {5'd1,  6'd0,  6'd0};
          86399:   want = {5'd23, 6'd59, 6'd59};
          86400:   want = 17'd0;
          default: want = {5'd0,  6'd0,  6'd1};
        endcase
        n_checks++;
        if (g !== want)
          $display("FAIL boundary%0d got %h want %h", n, g, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_prescale();
    rst4 = 1'b0;
    adv();
    n_checks++;
    if (got4() !== 17'd0)
      $display("FAIL pre_reset got %h want 0", got4());
    else n_pass++;
    rst4 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      adv();
      n_checks++;
      if (t4.sec !== 6'(n / 4) || got4() !== hms(m4))
        $display("FAIL pre_edge%0d got %h want sec %0d", n, got4(), n / 4);
      else n_pass++;
    end
    // 10 edges after release leaves the prescaler at 2.
    rst4 = 1'b0;
    adv();
    n_checks++;
    if (got4() !== 17'd0)
      $display("FAIL pre_midreset got %h want 0", got4());
    else n_pass++;
    rst4 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      adv();
      n_checks++;
      if (t4.sec !== ((n == 4) ? 6'd1 : 6'd0))
        $display("FAIL pre_restart%0d got %0d", n, t4.sec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst1 = ($urandom_range(0, 24) != 0);
      rst4 = ($urandom_range(0, 24) != 0);
      adv();
      n_checks++;
      if (got1() !== hms(m1))
        $display("FAIL rnd1_%0d got %h want %h", i, got1(), hms(m1));
      else n_pass++;
      n_checks++;
      if (got4() !== hms(m4))
        $display("FAIL rnd4_%0d got %h want %h", i, got4(), hms(m4));
      else n_pass++;
    end
    rst1 = 1'b1;
    rst4 = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m1 = 0;
    m4 = 0;
    e4 = 0;
    rst1 = 1'b0;
    rst4 = 1'b0;
    test_prescale();
    test_reset();
    test_mid_reset();
    test_day();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
